hood_mode_sequencer: RTL and testbench

Range-hood mode controller. It owns the fan-mode state machine (off, standby, level 1/2, one-shot hurricane, self-clean), runs the hurricane and self-clean countdowns, and drives `mode_state` to the timing/display block and the fan driver. It runs entirely on the 1 Hz tick. Button inputs are debounced and synchronised upstream and are sampled as levels on each `clk_1hz` rising edge.

---
 rtl/hood_mode_if.sv | 30 +++
 rtl/hood_mode_sequencer.sv | 129 ++++++++++++
 tb/tb_hood_mode_sequencer.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/hood_mode_if.sv
// hood_mode_if: request and status bundle between the hood controls and the mode sequencer.
`default_nettype none

interface hood_mode_if #(
  parameter int CNT_W = 8
);
  logic             power_on;
  logic             menu_req;
  logic             lvl1_req;
  logic             lvl2_req;
  logic             lvl3_req;
  logic             clean_req;
  logic [2:0]       mode_state;
  logic [CNT_W-1:0] countdown;
  logic             hurricane_used;
  logic             menu_latched;
  logic             clean_done;

  modport master (
    output power_on, menu_req, lvl1_req, lvl2_req, lvl3_req, clean_req,
    input  mode_state, countdown, hurricane_used, menu_latched, clean_done
  );

  modport slave (
    input  power_on, menu_req, lvl1_req, lvl2_req, lvl3_req, clean_req,
    output mode_state, countdown, hurricane_used, menu_latched, clean_done
  );
endinterface

`default_nettype wire

// File: rtl/hood_mode_sequencer.sv
// hood_mode_sequencer: range-hood fan-mode FSM with hurricane and self-clean countdowns on the 1 Hz tick.
`default_nettype none

module hood_mode_sequencer #(
  parameter int HURRICANE_SEC = 60,
  parameter int CLEAN_SEC     = 180,
  parameter int CNT_W         = 8
) (
  input  logic         clk_1hz,
  input  logic         rst,
  hood_mode_if.slave   bus
);

  typedef enum logic [2:0] {
    S_STANDBY   = 3'b000,
    S_L1        = 3'b001,
    S_L2        = 3'b010,
    S_HURRICANE = 3'b011,
    S_CLEAN     = 3'b100,
    S_OFF       = 3'b111
  } state_t;

  localparam logic [CNT_W-1:0] c_HURRICANE = CNT_W'(HURRICANE_SEC);
  localparam logic [CNT_W-1:0] c_CLEAN     = CNT_W'(CLEAN_SEC);
  localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_ZERO      = '0;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_used;
  logic             r_latched;
  logic             r_done;

  always_ff @(posedge clk_1hz or negedge rst) begin
    if (!rst) begin
      r_state   <= S_OFF;
      r_cnt     <= c_ZERO;
      r_used    <= 1'b0;
      r_latched <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!bus.power_on) begin
        r_state   <= S_OFF;
        r_cnt     <= c_ZERO;
        r_used    <= 1'b0;
        r_latched <= 1'b0;
      end else begin
        case (r_state)
          S_OFF: r_state <= S_STANDBY;

          // Menu outranks everything but has nothing to do in standby.
          S_STANDBY: begin
            if (bus.menu_req) begin
              r_state <= S_STANDBY;
            end else if (bus.clean_req) begin
              r_state <= S_CLEAN;
              r_cnt   <= c_CLEAN;
            end else if (bus.lvl3_req && !r_used) begin
              r_state   <= S_HURRICANE;
              r_cnt     <= c_HURRICANE;
              r_used    <= 1'b1;
              r_latched <= 1'b0;
            end else if (bus.lvl2_req) begin
              r_state <= S_L2;
            end else if (bus.lvl1_req) begin
              r_state <= S_L1;
            end
          end

          S_L1, S_L2: begin
            if (bus.menu_req) begin
              r_state <= S_STANDBY;
            end else if (bus.lvl3_req && !r_used) begin
              r_state   <= S_HURRICANE;
              r_cnt     <= c_HURRICANE;
              r_used    <= 1'b1;
              r_latched <= 1'b0;
            end else if (bus.lvl2_req) begin
              r_state <= S_L2;
            end else if (bus.lvl1_req) begin
              r_state <= S_L1;
            end
          end

          // Menu only arms the exit target; the hurricane always runs to completion.
          S_HURRICANE: begin
            if (bus.menu_req) begin
              r_latched <= 1'b1;
            end
            if (r_cnt <= c_ONE) begin
              r_state <= (r_latched || bus.menu_req) ? S_STANDBY : S_L2;
              r_cnt   <= c_ZERO;
            end else begin
              r_cnt <= r_cnt - c_ONE;
            end
          end

          S_CLEAN: begin
            if (bus.menu_req) begin
              r_state <= S_STANDBY;
              r_cnt   <= c_ZERO;
            end else if (r_cnt <= c_ONE) begin
              r_state <= S_STANDBY;
              r_cnt   <= c_ZERO;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - c_ONE;
            end
          end

          default: begin
            r_state <= S_OFF;
            r_cnt   <= c_ZERO;
          end
        endcase
      end
    end
  end

  assign bus.mode_state     = r_state;
  assign bus.countdown      = r_cnt;
  assign bus.hurricane_used = r_used;
  assign bus.menu_latched   = r_latched;
  assign bus.clean_done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_hood_mode_sequencer.sv
// tb_hood_mode_sequencer: directed stimulus with a queued scoreboard checked by an independent monitor.
`default_nettype none

module tb_hood_mode_sequencer;

  localparam logic [5:0] PW = 6'b100000;
  localparam logic [5:0] MN = 6'b010000;
  localparam logic [5:0] CL = 6'b001000;
  localparam logic [5:0] L3 = 6'b000100;
  localparam logic [5:0] L2 = 6'b000010;
  localparam logic [5:0] L1 = 6'b000001;

  typedef struct packed {
    logic [2:0] st;
    logic [7:0] cnt;
    logic       used;
    logic       lat;
    logic       done;
  } exp_t;

  logic clk_1hz;
  logic rst;
  int   n_tests;
  int   n_fail;
  exp_t  sb_q[$];
  string nm_q[$];

  hood_mode_if #(.CNT_W(8)) bus();

  hood_mode_sequencer #(
    .HURRICANE_SEC(60),
    .CLEAN_SEC(180),
    .CNT_W(8)
  ) dut (
    .clk_1hz(clk_1hz),
    .rst(rst),
    .bus(bus)
  );

  initial begin
    clk_1hz = 1'b0;
    forever #5 clk_1hz = ~clk_1hz;
  end

  function automatic exp_t actual();
    exp_t a;
    a.st   = bus.mode_state;
    a.cnt  = bus.countdown;
    a.used = bus.hurricane_used;
    a.lat  = bus.menu_latched;
    a.done = bus.clean_done;
    return a;
  endfunction

  task automatic compare(input exp_t e, input string name);
    exp_t a;
    a = actual();
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got st=%b cnt=%0d used=%b lat=%b done=%b, expected st=%b cnt=%0d used=%b lat=%b done=%b",
               name, a.st, a.cnt, a.used, a.lat, a.done, e.st, e.cnt, e.used, e.lat, e.done);
    end
  endtask

  // Monitor: every output update is checked against the oldest queued expectation.
  initial begin
    forever begin
      @(posedge clk_1hz);
      #1;
      if (sb_q.size() > 0) begin
        compare(sb_q.pop_front(), nm_q.pop_front());
      end
    end
  end

  task automatic step(input logic [5:0] req, input logic [2:0] st, input int cnt,
                      input logic used, input logic lat, input logic done, input string name);
    exp_t e;
    @(negedge clk_1hz);
    bus.power_on  = req[5];
    bus.menu_req  = req[4];
    bus.clean_req = req[3];
    bus.lvl3_req  = req[2];
    bus.lvl2_req  = req[1];
    bus.lvl1_req  = req[0];
    e.st   = st;
    e.cnt  = 8'(cnt);
    e.used = used;
    e.lat  = lat;
    e.done = done;
    sb_q.push_back(e);
    nm_q.push_back(name);
  endtask

  initial begin
    exp_t rv;
    n_tests = 0;
    n_fail  = 0;
    rv = '{st: 3'b111, cnt: 8'd0, used: 1'b0, lat: 1'b0, done: 1'b0};
    rst = 1'b1;
    {bus.power_on, bus.menu_req, bus.clean_req, bus.lvl3_req, bus.lvl2_req, bus.lvl1_req} = 6'b0;
    #2 rst = 1'b0;
    #1 compare(rv, "reset_values");
    #5 rst = 1'b1;

    // Hurricane, normal exit to L2
    step(PW,      3'b000, 0, 0, 0, 0, "power_on_standby");
    step(PW | L3, 3'b011, 60, 1, 0, 0, "hur_entry");
    for (int i = 59; i >= 1; i--) step(PW, 3'b011, i, 1, 0, 0, "hur_countdown");
    step(PW,      3'b010, 0, 1, 0, 0, "hur_exit_l2");
    step(PW | L3, 3'b010, 0, 1, 0, 0, "hur_no_retrigger");
    step(PW | MN, 3'b000, 0, 1, 0, 0, "l2_menu_standby");
    step(PW | L3, 3'b000, 0, 1, 0, 0, "standby_l3_used");

    // Hurricane with menu pressed mid-run
    step(6'b0,    3'b111, 0, 0, 0, 0, "power_off");
    step(PW | L3, 3'b000, 0, 0, 0, 0, "off_ignores_req");
    step(PW | L3, 3'b011, 60, 1, 0, 0, "hur2_entry");
    for (int i = 59; i >= 31; i--) step(PW, 3'b011, i, 1, 0, 0, "hur2_countdown");
    step(PW | MN, 3'b011, 30, 1, 1, 0, "hur2_menu_latch");
    for (int i = 29; i >= 1; i--) step(PW, 3'b011, i, 1, 1, 0, "hur2_countdown_lat");
    step(PW,      3'b000, 0, 1, 1, 0, "hur2_exit_standby");

    // Self-clean normal completion, then aborted run
    step(PW | MN | CL, 3'b000, 0, 1, 1, 0, "menu_over_clean");
    step(PW | CL, 3'b100, 180, 1, 1, 0, "clean_entry");
    for (int i = 179; i >= 1; i--) step(PW | L2, 3'b100, i, 1, 1, 0, "clean_countdown");
    step(PW,      3'b000, 0, 1, 1, 1, "clean_done_pulse");
    step(PW,      3'b000, 0, 1, 1, 0, "clean_done_one_cycle");
    step(PW | CL, 3'b100, 180, 1, 1, 0, "clean2_entry");
    for (int i = 179; i >= 51; i--) step(PW, 3'b100, i, 1, 1, 0, "clean2_countdown");
    step(PW | MN, 3'b000, 0, 1, 1, 0, "clean2_menu_abort");
    step(PW,      3'b000, 0, 1, 1, 0, "clean2_no_done");

    // Priority and level switching
    step(PW | CL | L3 | L2, 3'b100, 180, 1, 1, 0, "prio_clean_first");
    step(PW | MN, 3'b000, 0, 1, 1, 0, "prio_abort");
    step(PW | L1, 3'b001, 0, 1, 1, 0, "sb_to_l1");
    step(PW | MN | L2, 3'b000, 0, 1, 1, 0, "prio_menu_over_l2");
    step(PW | L1, 3'b001, 0, 1, 1, 0, "sb_to_l1_again");
    step(PW | L2, 3'b010, 0, 1, 1, 0, "l1_to_l2");
    step(PW | L1, 3'b001, 0, 1, 1, 0, "l2_to_l1");
    step(PW | CL, 3'b001, 0, 1, 1, 0, "l1_ignores_clean");

    // Power-off during hurricane re-arms it
    step(6'b0,    3'b111, 0, 0, 0, 0, "power_off2");
    step(PW,      3'b000, 0, 0, 0, 0, "power_on2");
    step(PW | L3, 3'b011, 60, 1, 0, 0, "hur3_entry");
    for (int i = 59; i >= 40; i--) step(PW, 3'b011, i, 1, 0, 0, "hur3_countdown");
    step(6'b0,    3'b111, 0, 0, 0, 0, "hur3_power_off");
    step(PW,      3'b000, 0, 0, 0, 0, "power_on3");
    step(PW | L3, 3'b011, 60, 1, 0, 0, "hur_rearmed");

    // Async reset in the middle of a clean countdown
    step(6'b0,    3'b111, 0, 0, 0, 0, "power_off3");
    step(PW,      3'b000, 0, 0, 0, 0, "power_on4");
    step(PW | CL, 3'b100, 180, 0, 0, 0, "clean3_entry");
    step(PW,      3'b100, 179, 0, 0, 0, "clean3_cd179");
    step(PW,      3'b100, 178, 0, 0, 0, "clean3_cd178");
    @(posedge clk_1hz);
    #3 rst = 1'b0;
    #1 compare(rv, "async_reset_mid_clean");
    #4 rst = 1'b1;
    step(PW,      3'b000, 0, 0, 0, 0, "after_reset_standby");

    // Drain with a bounded wait
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk_1hz);
    #2;
    if (sb_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
